// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: D/E/M-stage hazard inputs, memory handshake
// and the stall/flush/freeze/forward controls returned to the pipeline.
interface hazard_ctrl_if #(
   parameter int unsigned CNT_WIDTH = 32
);
   logic [4:0]           Rs1D;
   logic [4:0]           Rs2D;
   logic [4:0]           RdD;
   logic                 RegWriteD;
   logic [1:0]           ResultSrcD;
   logic                 PCSrcE;
   logic                 mem_reqM;
   logic                 mem_ready;
   logic                 StallF;
   logic                 StallD;
   logic                 FlushD;
   logic                 FlushE;
   logic                 Freeze;
   logic [1:0]           ForwardAE;
   logic [1:0]           ForwardBE;
   logic                 mem_err;
   logic [CNT_WIDTH-1:0] stall_cycles;

   // Pipeline side: supplies stage fields, consumes hazard controls.
   modport master (
      output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE, mem_reqM, mem_ready,
      input  StallF, StallD, FlushD, FlushE, Freeze, ForwardAE, ForwardBE, mem_err,
             stall_cycles
   );

   // Controller side.
   modport slave (
      input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE, mem_reqM, mem_ready,
      output StallF, StallD, FlushD, FlushE, Freeze, ForwardAE, ForwardBE, mem_err,
             stall_cycles
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: operand forwarding,
// load-use stall, branch flush and data-memory freeze with timeout flag.
module hazard_ctrl #(
   parameter int unsigned MAX_WAIT  = 15,
   parameter int unsigned CNT_WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave hz
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WaitMax  = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(MAX_WAIT - 1);

   typedef enum logic {StIdle, StWait} state_t;

   state_t               state;
   logic [WAIT_W-1:0]    waitCnt;
   logic                 memErr;
   logic [CNT_WIDTH-1:0] stallCnt;

   logic [4:0] Rs1E, Rs2E, RdE, RdM, RdW;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic [1:0] ResultSrcE;

   logic freeze, lwStall;

   function automatic logic [1:0] fwdSel(input logic [4:0] rs, input logic [4:0] rdM,
                                         input logic regWrM, input logic [4:0] rdW,
                                         input logic regWrW);
      if (regWrM && (rdM != 5'd0) && (rdM == rs))      return 2'b10;
      else if (regWrW && (rdW != 5'd0) && (rdW == rs)) return 2'b01;
      else                                             return 2'b00;
   endfunction

   assign freeze  = hz.mem_reqM && !hz.mem_ready;
   assign lwStall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == hz.Rs1D) || (RdE == hz.Rs2D));

   // Combinational hazard controls; freeze already holds everything, branch beats load-use.
   always_comb begin
      hz.Freeze    = freeze;
      hz.StallF    = lwStall && !hz.PCSrcE && !freeze;
      hz.StallD    = lwStall && !hz.PCSrcE && !freeze;
      hz.FlushD    = hz.PCSrcE && !freeze;
      hz.FlushE    = (lwStall || hz.PCSrcE) && !freeze;
      hz.ForwardAE = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      hz.ForwardBE = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
   end

   assign hz.mem_err      = memErr;
   assign hz.stall_cycles = stallCnt;

   // Shadow copy of the E/M/W destination and source fields; holds while frozen.
   always_ff @(posedge clk) begin
      if (rst) begin
         Rs1E       <= '0;
         Rs2E       <= '0;
         RdE        <= '0;
         RegWriteE  <= 1'b0;
         ResultSrcE <= '0;
         RdM        <= '0;
         RegWriteM  <= 1'b0;
         RdW        <= '0;
         RegWriteW  <= 1'b0;
      end else if (!freeze) begin
         if (hz.FlushE) begin
            Rs1E       <= '0;
            Rs2E       <= '0;
            RdE        <= '0;
            RegWriteE  <= 1'b0;
            ResultSrcE <= '0;
         end else begin
            Rs1E       <= hz.Rs1D;
            Rs2E       <= hz.Rs2D;
            RdE        <= hz.RdD;
            RegWriteE  <= hz.RegWriteD;
            ResultSrcE <= hz.ResultSrcD;
         end
         RdM       <= RdE;
         RegWriteM <= RegWriteE;
         RdW       <= RdM;
         RegWriteW <= RegWriteM;
      end
   end

   // Memory wait FSM; the wait counter stops at MAX_WAIT and the error flag is sticky.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= StIdle;
         waitCnt <= '0;
         memErr  <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (hz.mem_reqM && !hz.mem_ready) begin
                  state   <= StWait;
                  waitCnt <= '0;
               end
            end
            StWait: begin
               if (!hz.mem_reqM || hz.mem_ready) begin
                  state <= StIdle;
               end else if (waitCnt != WaitMax) begin
                  waitCnt <= waitCnt + 1'b1;
                  if (waitCnt == WaitLast) memErr <= 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   // Count cycles lost to freeze or load-use stall; wraps freely.
   always_ff @(posedge clk) begin
      if (rst)                       stallCnt <= '0;
      else if (freeze || hz.StallD)  stallCnt <= stallCnt + 1'b1;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MAX_WAIT = 4).
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] s0;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_WIDTH(32)) hz ();

   hazard_ctrl #(
      .MAX_WAIT (4),
      .CNT_WIDTH(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hz (hz)
   );

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setD(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic [1:0] rsrc);
      hz.Rs1D       = rs1;
      hz.Rs2D       = rs2;
      hz.RdD        = rd;
      hz.RegWriteD  = rw;
      hz.ResultSrcD = rsrc;
   endtask

   // Older producer rdA, younger producer rdB, then a consumer of rs1/rs2.
   task automatic runFwd(input string tag, input logic [4:0] rdA, input logic [4:0] rdB,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [1:0] expA, input logic [1:0] expB);
      setD(5'd0, 5'd0, rdA, 1'b1, 2'b00); tick();
      setD(5'd0, 5'd0, rdB, 1'b1, 2'b00); tick();
      setD(rs1, rs2, 5'd0, 1'b0, 2'b00);  tick();
      setD(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
      #1;
      checkEq({tag, "_A"}, 32'(hz.ForwardAE), 32'(expA));
      checkEq({tag, "_B"}, 32'(hz.ForwardBE), 32'(expB));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      setD(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
      hz.PCSrcE    = 1'b0;
      hz.mem_reqM  = 1'b0;
      hz.mem_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      // Reset state
      checkEq("rst_fwdA", 32'(hz.ForwardAE), 32'd0);
      checkEq("rst_fwdB", 32'(hz.ForwardBE), 32'd0);
      checkEq("rst_ctrl", {27'd0, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.Freeze}, 32'd0);
      checkEq("rst_err", 32'(hz.mem_err), 32'd0);
      checkEq("rst_cnt", hz.stall_cycles, 32'd0);

      // Forwarding priority
      runFwd("fwd_m_over_w", 5'd5, 5'd5, 5'd5, 5'd0, 2'b10, 2'b00);
      runFwd("fwd_w_only",   5'd5, 5'd6, 5'd5, 5'd6, 2'b01, 2'b10);
      runFwd("fwd_x0",       5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00);

      // Load-use: lw x7 in E, consumer uses x7 as rs2
      setD(5'd0, 5'd0, 5'd7, 1'b1, 2'b01); tick();
      setD(5'd1, 5'd7, 5'd8, 1'b1, 2'b00);
      #1;
      checkEq("lu_stall", {29'd0, hz.StallF, hz.StallD, hz.FlushE}, 32'b111);
      checkEq("lu_flushD", 32'(hz.FlushD), 32'd0);
      s0 = hz.stall_cycles;
      tick();
      checkEq("lu_oneshot", {29'd0, hz.StallF, hz.StallD, hz.FlushE}, 32'd0);
      checkEq("lu_cnt", hz.stall_cycles, s0 + 32'd1);
      tick();
      setD(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
      #1;
      checkEq("lu_fwdB_w", 32'(hz.ForwardBE), 32'b01);

      // Branch flush while load-use also present
      setD(5'd0, 5'd0, 5'd9, 1'b1, 2'b01); tick();
      setD(5'd9, 5'd0, 5'd3, 1'b1, 2'b00);
      hz.PCSrcE = 1'b1;
      #1;
      checkEq("br_flush", {30'd0, hz.FlushD, hz.FlushE}, 32'b11);
      checkEq("br_nostall", {30'd0, hz.StallF, hz.StallD}, 32'd0);
      s0 = hz.stall_cycles;
      tick();
      hz.PCSrcE = 1'b0;
      #1;
      checkEq("br_cnt", hz.stall_cycles, s0);
      checkEq("br_oneshot", {30'd0, hz.FlushD, hz.FlushE}, 32'd0);

      // Memory wait, 3 cycles; E consumer of x5 with x5 in M
      setD(5'd0, 5'd0, 5'd5, 1'b1, 2'b00); tick();
      setD(5'd5, 5'd0, 5'd0, 1'b0, 2'b00); tick();
      setD(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
      hz.mem_reqM = 1'b1;
      hz.PCSrcE   = 1'b1;
      #1;
      s0 = hz.stall_cycles;
      checkEq("mw_pre_fwdA", 32'(hz.ForwardAE), 32'b10);
      checkEq("mw_flush_masked", {30'd0, hz.FlushD, hz.FlushE}, 32'd0);
      hz.PCSrcE = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkEq($sformatf("mw_freeze%0d", i), 32'(hz.Freeze), 32'd1);
         checkEq($sformatf("mw_hold%0d", i), 32'(hz.ForwardAE), 32'b10);
         tick();
      end
      hz.mem_ready = 1'b1;
      #1;
      checkEq("mw_release", 32'(hz.Freeze), 32'd0);
      checkEq("mw_cnt", hz.stall_cycles, s0 + 32'd3);
      tick();
      hz.mem_reqM  = 1'b0;
      hz.mem_ready = 1'b0;
      #1;
      checkEq("mw_noerr", 32'(hz.mem_err), 32'd0);

      // Zero-wait access
      hz.mem_reqM  = 1'b1;
      hz.mem_ready = 1'b1;
      #1;
      checkEq("zw_nofreeze", 32'(hz.Freeze), 32'd0);
      tick();
      hz.mem_reqM  = 1'b0;
      hz.mem_ready = 1'b0;

      // Timeout: 6 cycles of waiting with MAX_WAIT = 4
      hz.mem_reqM = 1'b1;
      s0 = hz.stall_cycles;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (i == 3) checkEq("to_early", 32'(hz.mem_err), 32'd0);
         tick();
      end
      checkEq("to_set", 32'(hz.mem_err), 32'd1);
      checkEq("to_cnt", hz.stall_cycles, s0 + 32'd6);
      hz.mem_ready = 1'b1;
      tick();
      hz.mem_reqM  = 1'b0;
      hz.mem_ready = 1'b0;
      tick();
      checkEq("to_sticky", 32'(hz.mem_err), 32'd1);

      // Reset on the 2nd WAIT cycle
      setD(5'd0, 5'd0, 5'd5, 1'b1, 2'b00); tick();
      setD(5'd5, 5'd5, 5'd0, 1'b0, 2'b00); tick();
      setD(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
      hz.mem_reqM = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst         = 1'b0;
      hz.mem_reqM = 1'b0;
      #1;
      checkEq("rw_cnt", hz.stall_cycles, 32'd0);
      checkEq("rw_err", 32'(hz.mem_err), 32'd0);
      checkEq("rw_fwd", {28'd0, hz.ForwardAE, hz.ForwardBE}, 32'd0);
      checkEq("rw_freeze", 32'(hz.Freeze), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
